eth_rx_checker: RTL

- Receive-side traffic checker for the 10G Ethernet path. It consumes the MAC RX AXI-Stream, classifies each frame, and extracts a 32-bit big-endian sequence number from test frames.
- It counts good, bad, foreign and out-of-sequence frames, and optionally measures inter-frame gap in clock cycles.
- It sits after the MAC RX in eth_top and is the check end for frames produced by the TX generator (ifg_len-spaced).

---
 rtl/eth_rx_checker.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_checker.sv
// Receive-side traffic checker: classifies MAC RX frames, tracks test-frame sequence numbers, keeps statistics.
// Define RX_IFG_MEASURE_EN to build inter-frame gap measurement (ifg_min/ifg_max); otherwise both read 0.
module eth_rx_checker #(
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned IFG_W     = 28
) (
  input  logic             user_clk,
  input  logic             cold_reset_n,
  input  logic [63:0]      s_axis_rx_tdata,
  input  logic [7:0]       s_axis_rx_tkeep,
  input  logic             s_axis_rx_tlast,
  input  logic             s_axis_rx_tuser,
  input  logic             s_axis_rx_tvalid,
  output logic             s_axis_rx_tready,
  input  logic             stat_clear,
  output logic [CNT_W-1:0] rx_pkt_cnt,
  output logic [CNT_W-1:0] rx_other_cnt,
  output logic [CNT_W-1:0] rx_bad_cnt,
  output logic [CNT_W-1:0] seq_err_cnt,
  output logic [31:0]      last_seq,
  output logic             seq_locked,
  output logic [IFG_W-1:0] ifg_min,
  output logic [IFG_W-1:0] ifg_max
);

  typedef enum logic [2:0] {IDLE, HDR1, HDR2, BODY, DROP} state_e;

  state_e           state_q;
  logic             ready_q;
  logic [15:0]      etype_q;
  logic [15:0]      seq_hi_q;
  logic [15:0]      seq_lo_q;
  logic             end_vld_q;
  logic             end_bad_q;
  logic             end_other_q;
  logic [31:0]      end_seq_q;
  logic [CNT_W-1:0] pkt_cnt_q;
  logic [CNT_W-1:0] other_cnt_q;
  logic [CNT_W-1:0] bad_cnt_q;
  logic [CNT_W-1:0] seq_err_cnt_q;
  logic [31:0]      last_seq_q;
  logic             seq_locked_q;

  logic             accept;
  logic             frame_end;
  logic             runt;
  logic [31:0]      seq_d;
  logic             unused_bits;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign accept           = s_axis_rx_tvalid & ready_q;
  assign s_axis_rx_tready = ready_q;
  assign unused_bits      = ^{s_axis_rx_tdata[31:16], s_axis_rx_tkeep[7:2], s_axis_rx_tkeep[0]};

  // A frame ending on beat 2 carries the low sequence half on the bus, not yet in seq_lo_q.
  always_comb begin
    frame_end = 1'b0;
    runt      = 1'b0;
    seq_d     = {seq_hi_q, seq_lo_q};
    if (accept && s_axis_rx_tlast) begin
      case (state_q)
        IDLE, HDR1: begin
          frame_end = 1'b1;
          runt      = 1'b1;
        end
        HDR2: begin
          frame_end = 1'b1;
          runt      = ~s_axis_rx_tkeep[1];
          seq_d     = {seq_hi_q, s_axis_rx_tdata[7:0], s_axis_rx_tdata[15:8]};
        end
        BODY:    frame_end = 1'b1;
        default: frame_end = 1'b0;
      endcase
    end
  end

  always_ff @(posedge user_clk or negedge cold_reset_n) begin
    if (!cold_reset_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      etype_q     <= '0;
      seq_hi_q    <= '0;
      seq_lo_q    <= '0;
      end_vld_q   <= 1'b0;
      end_bad_q   <= 1'b0;
      end_other_q <= 1'b0;
      end_seq_q   <= '0;
    end else begin
      ready_q     <= 1'b1;
      end_vld_q   <= frame_end & ~stat_clear;
      end_bad_q   <= runt | s_axis_rx_tuser;
      end_other_q <= (etype_q != ETHERTYPE);
      end_seq_q   <= seq_d;
      if (accept) begin
        case (state_q)
          IDLE: state_q <= s_axis_rx_tlast ? IDLE : HDR1;
          HDR1: begin
            etype_q  <= {s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]};
            seq_hi_q <= {s_axis_rx_tdata[55:48], s_axis_rx_tdata[63:56]};
            state_q  <= s_axis_rx_tlast ? IDLE : HDR2;
          end
          HDR2: begin
            seq_lo_q <= {s_axis_rx_tdata[7:0], s_axis_rx_tdata[15:8]};
            state_q  <= s_axis_rx_tlast ? IDLE : BODY;
          end
          BODY, DROP: if (s_axis_rx_tlast) state_q <= IDLE;
          default:    state_q <= IDLE;
        endcase
      end
      // Clear aborts any frame still open after this beat; its remainder is swallowed in DROP.
      if (stat_clear && !(accept && s_axis_rx_tlast) && (accept || state_q != IDLE))
        state_q <= DROP;
    end
  end

  always_ff @(posedge user_clk or negedge cold_reset_n) begin
    if (!cold_reset_n) begin
      pkt_cnt_q     <= '0;
      other_cnt_q   <= '0;
      bad_cnt_q     <= '0;
      seq_err_cnt_q <= '0;
      last_seq_q    <= '0;
      seq_locked_q  <= 1'b0;
    end else if (stat_clear) begin
      pkt_cnt_q     <= '0;
      other_cnt_q   <= '0;
      bad_cnt_q     <= '0;
      seq_err_cnt_q <= '0;
      last_seq_q    <= '0;
      seq_locked_q  <= 1'b0;
    end else if (end_vld_q) begin
      if (end_bad_q) begin
        bad_cnt_q <= sat_inc(bad_cnt_q);
      end else if (end_other_q) begin
        other_cnt_q <= sat_inc(other_cnt_q);
      end else begin
        pkt_cnt_q    <= sat_inc(pkt_cnt_q);
        last_seq_q   <= end_seq_q;
        seq_locked_q <= 1'b1;
        if (seq_locked_q && (end_seq_q != last_seq_q + 32'd1))
          seq_err_cnt_q <= sat_inc(seq_err_cnt_q);
      end
    end
  end

  assign rx_pkt_cnt   = pkt_cnt_q;
  assign rx_other_cnt = other_cnt_q;
  assign rx_bad_cnt   = bad_cnt_q;
  assign seq_err_cnt  = seq_err_cnt_q;
  assign last_seq     = last_seq_q;
  assign seq_locked   = seq_locked_q;

`ifdef RX_IFG_MEASURE_EN
  logic [IFG_W-1:0] gap_q;
  logic             gap_arm_q;
  logic [IFG_W-1:0] ifg_min_q;
  logic [IFG_W-1:0] ifg_max_q;

  // gap_q restarts at 0 on every tlast; it is only sampled by the next first beat while armed.
  always_ff @(posedge user_clk or negedge cold_reset_n) begin
    if (!cold_reset_n) begin
      gap_q     <= '0;
      gap_arm_q <= 1'b0;
      ifg_min_q <= '1;
      ifg_max_q <= '0;
    end else if (stat_clear) begin
      gap_q     <= '0;
      gap_arm_q <= 1'b0;
      ifg_min_q <= '1;
      ifg_max_q <= '0;
    end else begin
      if (accept && state_q == IDLE && gap_arm_q) begin
        if (gap_q < ifg_min_q) ifg_min_q <= gap_q;
        if (gap_q > ifg_max_q) ifg_max_q <= gap_q;
      end
      if (accept && s_axis_rx_tlast) begin
        gap_q     <= '0;
        gap_arm_q <= (state_q != DROP);
      end else if (!(&gap_q)) begin
        gap_q <= gap_q + IFG_W'(1);
      end
    end
  end

  assign ifg_min = ifg_min_q;
  assign ifg_max = ifg_max_q;
`else
  assign ifg_min = '0;
  assign ifg_max = '0;
`endif

endmodule
